// File: rtl/mips_cpu_pkg.sv
// Shared constants, types and helpers for the MIPS CPU instruction-side blocks.
package mips_cpu_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] NOP_INSTR    = 32'h0;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } loader_state_t;

  // Converts a big-endian assembled word into the CPU's little-endian byte order.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mips_cpu_word_packer.sv
// Packs a big-endian byte stream into 32-bit words.
// The partial word is cleared after each emitted word, so lanes that were
// never filled read as zero when a short final word is flushed.
module mips_cpu_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  input  logic        last,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        short_word
);

  logic [1:0]  byte_idx;
  logic [31:0] partial;
  logic [31:0] lane_word;

  // Place the incoming byte in its lane (byte 0 -> [31:24]) and flag word completion.
  always_comb begin
    lane_word  = 32'(byte_data) << {~byte_idx, 3'b000};
    word       = partial | lane_word;
    word_valid = accept && ((byte_idx == 2'd3) || last);
    short_word = accept && last && (byte_idx != 2'd3);
  end

  // Advance the byte counter and hold the partial word between accepted bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= 2'd0;
      partial  <= 32'h0;
    end else if (accept) begin
      if (word_valid) begin
        byte_idx <= 2'd0;
        partial  <= 32'h0;
      end else begin
        byte_idx <= byte_idx + 2'd1;
        partial  <= word;
      end
    end
  end

endmodule

// File: rtl/mips_cpu_instr_loader_memory.sv
// Loadable instruction memory for mips_cpu_harvard: serial byte loader,
// CPU reset hold during loading, and combinational fetch port.
//
//   state | meaning
//   LOAD  | accepting program bytes, CPU held in reset, fetches return nop
//   RUN   | loading closed, CPU released, fetches served from memory
module mips_cpu_instr_loader_memory
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          DEPTH_WORDS = 64,
  localparam int         AW          = $clog2(DEPTH_WORDS),
  localparam int         CW          = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_enable,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  input  logic          load_last,
  output logic          load_ready,
  output logic          cpu_reset,
  input  logic [31:0]   instr_address,
  output logic [31:0]   instr_readdata,
  output logic          load_error,
  output logic          fetch_fault,
  output logic [CW-1:0] word_count
);

  localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH_WORDS - 1);

  loader_state_t state;
  logic          accept;
  logic          word_valid;
  logic          short_word;
  logic [31:0]   packed_word;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic [29:0]   idx;
  logic          hit;
  logic          fault_now;

  assign load_ready = (state == LOAD) && clk_enable;
  assign cpu_reset  = (state == LOAD);
  assign accept     = load_valid && load_ready;

  mips_cpu_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .accept     (accept),
    .byte_data  (load_data),
    .last       (load_last),
    .word       (packed_word),
    .word_valid (word_valid),
    .short_word (short_word)
  );

  // Loader FSM, word counter and sticky status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= LOAD;
      word_count  <= '0;
      load_error  <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (clk_enable) begin
      if (word_valid) begin
        word_count <= word_count + 1'b1;
        if (short_word) load_error <= 1'b1;
        if (load_last || (word_count == LAST_SLOT)) state <= RUN;
      end
      if ((state == RUN) && fault_now) fetch_fault <= 1'b1;
    end
  end

  // Program storage; contents survive reset, word_count decides what is visible.
  always_ff @(posedge clk) begin
    if (word_valid) mem[word_count[AW-1:0]] <= packed_word;
  end

  // Zero-latency fetch decode; address 0 is the CPU halt address and never faults.
  always_comb begin
    offset         = instr_address - BASE_ADDR;
    idx            = offset[31:2];
    hit            = (state == RUN) && (offset[1:0] == 2'b00) &&
                     (idx < {{(30 - CW){1'b0}}, word_count});
    instr_readdata = hit ? bswap32(mem[idx[AW-1:0]]) : NOP_INSTR;
    fault_now      = (state == RUN) && !hit && (instr_address != 32'h0);
  end

endmodule

// File: tb/tb_mips_cpu_instr_loader_memory.sv
// Self-checking bench for mips_cpu_instr_loader_memory.
module tb_mips_cpu_instr_loader_memory;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        cpu_reset;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        load_error;
  logic        fetch_fault;
  logic [6:0]  word_count;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  mips_cpu_instr_loader_memory #(.BASE_ADDR(BASE), .DEPTH_WORDS(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_last      (load_last),
    .load_ready     (load_ready),
    .cpu_reset      (cpu_reset),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .load_error     (load_error),
    .fetch_fault    (fetch_fault),
    .word_count     (word_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tb_swap(input logic [31:0] w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = w[8*(3-k) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] prog13(input int i);
    if (i == 0)  return 32'h24010020;
    if (i == 12) return 32'h24000000;
    return 32'h3C000000 + i * 32'h00010101;
  endfunction

  task automatic do_reset();
    sb.delete();
    instr_address = 32'h0;
    clk_enable    = 1'b1;
    load_valid    = 1'b0;
    load_last     = 1'b0;
    load_data     = 8'h00;
    reset         = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = b;
    load_last  = last;
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic send_word(input int i, input logic [31:0] w, input logic last);
    for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], last && (b == 3));
    sb.push_back('{BASE + 32'(4 * i), tb_swap(w)});
  endtask

  task automatic load_program13();
    do_reset();
    for (int i = 0; i < 13; i++) send_word(i, prog13(i), i == 12);
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    instr_address = BASE;
    #1;
    n_checks++; if (load_ready !== 1'b1) $display("FAIL reset_load_ready: got %b expected 1", load_ready); else n_pass++;
    n_checks++; if (cpu_reset !== 1'b1) $display("FAIL reset_cpu_reset: got %b expected 1", cpu_reset); else n_pass++;
    n_checks++; if (word_count !== 7'd0) $display("FAIL reset_word_count: got %0d expected 0", word_count); else n_pass++;
    n_checks++; if (load_error !== 1'b0) $display("FAIL reset_load_error: got %b expected 0", load_error); else n_pass++;
    n_checks++; if (fetch_fault !== 1'b0) $display("FAIL reset_fetch_fault: got %b expected 0", fetch_fault); else n_pass++;
    n_checks++; if (instr_readdata !== 32'h0) $display("FAIL reset_readdata: got %h expected 00000000", instr_readdata); else n_pass++;
  endtask

  task automatic test_program13();
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 12; i++) send_word(i, prog13(i), 1'b0);
    w = prog13(12);
    for (int b = 0; b < 3; b++) send_byte(w[31-8*b -: 8], 1'b0);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = w[7:0];
    load_last  = 1'b1;
    n_checks++; if (cpu_reset !== 1'b1) $display("FAIL p13_cpu_reset_before: got %b expected 1", cpu_reset); else n_pass++;
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    sb.push_back('{BASE + 32'd48, tb_swap(w)});
    n_checks++; if (cpu_reset !== 1'b0) $display("FAIL p13_cpu_reset_after: got %b expected 0", cpu_reset); else n_pass++;
    n_checks++; if (word_count !== 7'd13) $display("FAIL p13_word_count: got %0d expected 13", word_count); else n_pass++;
    n_checks++; if (load_error !== 1'b0) $display("FAIL p13_load_error: got %b expected 0", load_error); else n_pass++;
    n_checks++; if (sb[0].data !== 32'h20000124) $display("FAIL p13_model_word0: got %h expected 20000124", sb[0].data); else n_pass++;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      instr_address = e.addr;
      #1;
      n_checks++;
      if (instr_readdata !== e.data) $display("FAIL p13_fetch %h: got %h expected %h", e.addr, instr_readdata, e.data);
      else n_pass++;
    end
    n_checks++; if (fetch_fault !== 1'b0) $display("FAIL p13_no_fault: got %b expected 0", fetch_fault); else n_pass++;
  endtask

  task automatic test_pad_error();
    do_reset();
    send_word(0, 32'h11223344, 1'b0);
    send_byte(8'h55, 1'b1);
    sb.push_back('{BASE + 32'd4, 32'h00000055});
    sb.push_back('{BASE + 32'd8, 32'h00000000});
    n_checks++; if (load_error !== 1'b1) $display("FAIL pad_load_error: got %b expected 1", load_error); else n_pass++;
    n_checks++; if (word_count !== 7'd2) $display("FAIL pad_word_count: got %0d expected 2", word_count); else n_pass++;
    n_checks++; if (cpu_reset !== 1'b0) $display("FAIL pad_cpu_reset: got %b expected 0", cpu_reset); else n_pass++;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      instr_address = e.addr;
      #1;
      n_checks++;
      if (instr_readdata !== e.data) $display("FAIL pad_fetch %h: got %h expected %h", e.addr, instr_readdata, e.data);
      else n_pass++;
    end
  endtask

  task automatic test_full();
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 63; i++) send_word(i, {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'hC3}, 1'b0);
    w = {8'd63, ~8'd63, 8'd63 ^ 8'h5A, 8'hC3};
    for (int b = 0; b < 3; b++) send_byte(w[31-8*b -: 8], 1'b0);
    n_checks++; if (load_ready !== 1'b1) $display("FAIL full_ready_before: got %b expected 1", load_ready); else n_pass++;
    send_byte(w[7:0], 1'b0);
    sb.push_back('{BASE + 32'd252, tb_swap(w)});
    n_checks++; if (load_ready !== 1'b0) $display("FAIL full_ready_after: got %b expected 0", load_ready); else n_pass++;
    n_checks++; if (cpu_reset !== 1'b0) $display("FAIL full_cpu_reset: got %b expected 0", cpu_reset); else n_pass++;
    n_checks++; if (word_count !== 7'd64) $display("FAIL full_word_count: got %0d expected 64", word_count); else n_pass++;
    send_byte(8'hEE, 1'b0);
    send_byte(8'hEE, 1'b1);
    n_checks++; if (word_count !== 7'd64) $display("FAIL full_extra_byte: got %0d expected 64", word_count); else n_pass++;
    n_checks++; if (load_error !== 1'b0) $display("FAIL full_load_error: got %b expected 0", load_error); else n_pass++;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      instr_address = e.addr;
      #1;
      n_checks++;
      if (instr_readdata !== e.data) $display("FAIL full_fetch %h: got %h expected %h", e.addr, instr_readdata, e.data);
      else n_pass++;
    end
  endtask

  task automatic test_fetch_fault();
    load_program13();
    instr_address = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++; if (fetch_fault !== 1'b0) $display("FAIL fault_halt_addr: got %b expected 0", fetch_fault); else n_pass++;
    n_checks++; if (instr_readdata !== 32'h0) $display("FAIL fault_halt_data: got %h expected 00000000", instr_readdata); else n_pass++;
    instr_address = BASE + 32'd2;
    #1;
    n_checks++; if (instr_readdata !== 32'h0) $display("FAIL fault_misaligned_data: got %h expected 00000000", instr_readdata); else n_pass++;
    @(negedge clk);
    n_checks++; if (fetch_fault !== 1'b1) $display("FAIL fault_misaligned: got %b expected 1", fetch_fault); else n_pass++;
    load_program13();
    instr_address = BASE + 32'h100;
    #1;
    n_checks++; if (instr_readdata !== 32'h0) $display("FAIL fault_range_data: got %h expected 00000000", instr_readdata); else n_pass++;
    @(negedge clk);
    n_checks++; if (fetch_fault !== 1'b1) $display("FAIL fault_range: got %b expected 1", fetch_fault); else n_pass++;
    load_program13();
    instr_address = BASE + 32'd52;
    @(negedge clk);
    n_checks++; if (fetch_fault !== 1'b1) $display("FAIL fault_unloaded: got %b expected 1", fetch_fault); else n_pass++;
  endtask

  task automatic test_reset_midload();
    do_reset();
    for (int b = 1; b <= 6; b++) send_byte(8'(b), 1'b0);
    n_checks++; if (word_count !== 7'd1) $display("FAIL mid_count_before: got %0d expected 1", word_count); else n_pass++;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (word_count !== 7'd0) $display("FAIL mid_count_reset: got %0d expected 0", word_count); else n_pass++;
    n_checks++; if (cpu_reset !== 1'b1) $display("FAIL mid_cpu_reset: got %b expected 1", cpu_reset); else n_pass++;
    n_checks++; if (load_ready !== 1'b1) $display("FAIL mid_load_ready: got %b expected 1", load_ready); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    send_word(0, 32'hAABBCCDD, 1'b1);
    sb.push_back('{BASE + 32'd4, 32'h00000000});
    n_checks++; if (word_count !== 7'd1) $display("FAIL mid_count_reload: got %0d expected 1", word_count); else n_pass++;
    n_checks++; if (load_error !== 1'b0) $display("FAIL mid_load_error: got %b expected 0", load_error); else n_pass++;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      instr_address = e.addr;
      #1;
      n_checks++;
      if (instr_readdata !== e.data) $display("FAIL mid_fetch %h: got %h expected %h", e.addr, instr_readdata, e.data);
      else n_pass++;
    end
  endtask

  task automatic test_clk_enable();
    do_reset();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    @(negedge clk);
    clk_enable = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'h77;
    load_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (load_ready !== 1'b0) $display("FAIL ce_load_ready cycle %0d: got %b expected 0", c, load_ready); else n_pass++;
    end
    n_checks++; if (word_count !== 7'd0) $display("FAIL ce_word_count: got %0d expected 0", word_count); else n_pass++;
    n_checks++; if (cpu_reset !== 1'b1) $display("FAIL ce_cpu_reset: got %b expected 1", cpu_reset); else n_pass++;
    load_valid = 1'b0;
    load_last  = 1'b0;
    clk_enable = 1'b1;
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b1);
    sb.push_back('{BASE, tb_swap(32'h12345678)});
    n_checks++; if (word_count !== 7'd1) $display("FAIL ce_resume_count: got %0d expected 1", word_count); else n_pass++;
    n_checks++; if (load_error !== 1'b0) $display("FAIL ce_load_error: got %b expected 0", load_error); else n_pass++;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      instr_address = e.addr;
      #1;
      n_checks++;
      if (instr_readdata !== e.data) $display("FAIL ce_fetch %h: got %h expected %h", e.addr, instr_readdata, e.data);
      else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_program13();
    test_pad_error();
    test_fetch_fault();
    test_reset_midload();
    test_clk_enable();
    test_full();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
